// File: rtl/caxi4interconnect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | caxi4interconnect_pkg: shared AXI widths, W FSM encoding and clog2.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package caxi4interconnect_pkg;

  localparam int AXI_LEN_W = 8;

  typedef enum logic [0:0] {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } w_state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mstr_wr_len_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mstr_wr_len_fifo: first-word-fall-through FIFO of burst lengths.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mstr_wr_len_fifo
  import caxi4interconnect_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [AXI_LEN_W-1:0] data_i,
  input  logic                 pop_i,
  output logic [AXI_LEN_W-1:0] head_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CNT_W-1:0]     count_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [AXI_LEN_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage carries no reset; occupancy is owned entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mstr_wr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mstr_wr_sequencer: AW-before-W ordering, outstanding cap, WLAST      |
// | regeneration and master protocol error flags.  Revision: 1.0         |
// +----------------------------------------------------------------------+
module mstr_wr_sequencer
  import caxi4interconnect_pkg::*;
#(
  parameter  int ID_WIDTH        = 1,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W           = clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 ACLK,
  input  logic                 sysReset,
  input  logic                 MASTER_AWVALID,
  input  logic [AXI_LEN_W-1:0] MASTER_AWLEN,
  output logic                 MASTER_AWREADY,
  output logic                 int_masterAWVALID,
  input  logic                 int_masterAWREADY,
  input  logic                 MASTER_WVALID,
  input  logic                 MASTER_WLAST,
  output logic                 MASTER_WREADY,
  output logic                 int_masterWVALID,
  output logic                 int_masterWLAST,
  input  logic                 int_masterWREADY,
  input  logic                 int_masterBVALID,
  input  logic [ID_WIDTH-1:0]  int_masterBID,
  input  logic                 MASTER_BREADY,
  output logic [CNT_W-1:0]     outstanding_cnt,
  output logic                 err_wlast,
  output logic                 err_unexp_b
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  w_state_e             state_q;
  logic [AXI_LEN_W-1:0] beat_q;
  logic [CNT_W-1:0]     out_cnt_q;
  logic [CNT_W-1:0]     out_cnt_d;
  logic                 en_q;
  logic                 err_wlast_q;
  logic                 err_unexp_b_q;

  logic                 active;
  logic                 space;
  logic                 in_burst;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 b_hs;
  logic                 last_hs;
  logic                 more;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [AXI_LEN_W-1:0] fifo_head;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 bid_unused;

  assign bid_unused = ^int_masterBID;

  // en_q keeps every handshake closed for the first cycle after reset release.
  assign active            = en_q & ~sysReset;
  assign space             = active && (out_cnt_q < MAX_CNT) && !fifo_full;
  assign int_masterAWVALID = MASTER_AWVALID & space;
  assign MASTER_AWREADY    = int_masterAWREADY & space;
  assign aw_hs             = int_masterAWVALID & int_masterAWREADY;

  assign in_burst          = (state_q == W_BURST);
  assign int_masterWVALID  = MASTER_WVALID & in_burst & active;
  assign MASTER_WREADY     = int_masterWREADY & in_burst & active;
  assign int_masterWLAST   = in_burst & (beat_q == fifo_head);
  assign w_hs              = int_masterWVALID & int_masterWREADY;
  assign last_hs           = w_hs & int_masterWLAST;
  assign b_hs              = int_masterBVALID & MASTER_BREADY;
  assign more              = (fifo_cnt > ONE_CNT) | aw_hs;

  assign outstanding_cnt   = out_cnt_q;
  assign err_wlast         = err_wlast_q;
  assign err_unexp_b       = err_unexp_b_q;

  mstr_wr_len_fifo #(
    .DEPTH   (MAX_OUTSTANDING)
  ) u_len_fifo (
    .clk_i   (ACLK),
    .rst_i   (sysReset),
    .push_i  (aw_hs),
    .data_i  (MASTER_AWLEN),
    .pop_i   (last_hs),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Entering on the push itself lets the first beat follow its AW by one cycle.
  always_ff @(posedge ACLK) begin
    if (sysReset) begin
      state_q <= W_IDLE;
      beat_q  <= '0;
    end else begin
      case (state_q)
        W_IDLE: begin
          beat_q <= '0;
          if (!fifo_empty || aw_hs) begin
            state_q <= W_BURST;
          end
        end
        W_BURST: begin
          if (last_hs) begin
            beat_q  <= '0;
            state_q <= more ? W_BURST : W_IDLE;
          end else if (w_hs) begin
            beat_q  <= beat_q + 1'b1;
          end
        end
        default: begin
          state_q <= W_IDLE;
          beat_q  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (aw_hs && !b_hs) begin
      out_cnt_d = out_cnt_q + ONE_CNT;
    end else if (b_hs && !aw_hs && (out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q - ONE_CNT;
    end
  end

  always_ff @(posedge ACLK) begin
    if (sysReset) begin
      en_q          <= 1'b0;
      out_cnt_q     <= '0;
      err_wlast_q   <= 1'b0;
      err_unexp_b_q <= 1'b0;
    end else begin
      en_q      <= 1'b1;
      out_cnt_q <= out_cnt_d;
      if (w_hs && (MASTER_WLAST != int_masterWLAST)) begin
        err_wlast_q <= 1'b1;
      end
      if (b_hs && (out_cnt_q == '0)) begin
        err_unexp_b_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mstr_wr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mstr_wr_sequencer: directed scenarios plus randomized traffic      |
// | against a queue-based reference model.  Revision: 1.0                |
// +----------------------------------------------------------------------+
module tb_mstr_wr_sequencer;

  localparam int MAXO = 4;

  logic       ACLK = 1'b0;
  logic       sysReset = 1'b1;
  logic       MASTER_AWVALID = 1'b0;
  logic [7:0] MASTER_AWLEN = 8'd0;
  logic       MASTER_AWREADY;
  logic       int_masterAWVALID;
  logic       int_masterAWREADY = 1'b0;
  logic       MASTER_WVALID = 1'b0;
  logic       MASTER_WLAST = 1'b0;
  logic       MASTER_WREADY;
  logic       int_masterWVALID;
  logic       int_masterWLAST;
  logic       int_masterWREADY = 1'b0;
  logic       int_masterBVALID = 1'b0;
  logic [0:0] int_masterBID = 1'b0;
  logic       MASTER_BREADY = 1'b0;
  logic [2:0] outstanding_cnt;
  logic       err_wlast;
  logic       err_unexp_b;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of accepted burst lengths, beat index into the head.
  int unsigned mq[$];
  int          m_beat = 0;
  int          m_cnt  = 0;
  bit          m_en   = 1'b0;
  bit          m_errw = 1'b0;
  bit          m_errb = 1'b0;

  mstr_wr_sequencer #(
    .ID_WIDTH        (1),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .ACLK              (ACLK),
    .sysReset          (sysReset),
    .MASTER_AWVALID    (MASTER_AWVALID),
    .MASTER_AWLEN      (MASTER_AWLEN),
    .MASTER_AWREADY    (MASTER_AWREADY),
    .int_masterAWVALID (int_masterAWVALID),
    .int_masterAWREADY (int_masterAWREADY),
    .MASTER_WVALID     (MASTER_WVALID),
    .MASTER_WLAST      (MASTER_WLAST),
    .MASTER_WREADY     (MASTER_WREADY),
    .int_masterWVALID  (int_masterWVALID),
    .int_masterWLAST   (int_masterWLAST),
    .int_masterWREADY  (int_masterWREADY),
    .int_masterBVALID  (int_masterBVALID),
    .int_masterBID     (int_masterBID),
    .MASTER_BREADY     (MASTER_BREADY),
    .outstanding_cnt   (outstanding_cnt),
    .err_wlast         (err_wlast),
    .err_unexp_b       (err_unexp_b)
  );

  always #5 ACLK = ~ACLK;

  function automatic bit m_space();
    return m_en && !sysReset && (m_cnt < MAXO) && (mq.size() < MAXO);
  endfunction

  function automatic bit m_wact();
    return m_en && !sysReset && (mq.size() > 0);
  endfunction

  function automatic bit e_wlast();
    return (mq.size() > 0) && (m_beat == int'(mq[0]));
  endfunction

  task automatic model_update();
    bit aw;
    bit w;
    bit b;
    bit last;
    if (sysReset) begin
      mq.delete();
      m_beat = 0;
      m_cnt  = 0;
      m_en   = 1'b0;
      m_errw = 1'b0;
      m_errb = 1'b0;
    end else begin
      aw   = MASTER_AWVALID && int_masterAWREADY && m_space();
      w    = MASTER_WVALID && int_masterWREADY && m_wact();
      b    = int_masterBVALID && MASTER_BREADY;
      last = e_wlast();
      if (w) begin
        if (MASTER_WLAST != last) m_errw = 1'b1;
        if (last) begin
          void'(mq.pop_front());
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (aw) mq.push_back(int'(MASTER_AWLEN));
      if (b && m_cnt == 0) m_errb = 1'b1;
      if (aw && !b) m_cnt++;
      else if (b && !aw && m_cnt > 0) m_cnt--;
      m_en = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    model_update();
    #1;
  endtask

  task automatic idle();
    MASTER_AWVALID    = 1'b0;
    int_masterAWREADY = 1'b0;
    MASTER_WVALID     = 1'b0;
    MASTER_WLAST      = 1'b0;
    int_masterWREADY  = 1'b0;
    int_masterBVALID  = 1'b0;
    MASTER_BREADY     = 1'b0;
  endtask

  task automatic b_handshake(input int n);
    int_masterBVALID = 1'b1;
    MASTER_BREADY    = 1'b1;
    repeat (n) step();
    int_masterBVALID = 1'b0;
    MASTER_BREADY    = 1'b0;
  endtask

  task automatic test_reset();
    sysReset = 1'b1;
    MASTER_AWVALID = 1'b1; int_masterAWREADY = 1'b1;
    MASTER_WVALID = 1'b1;  int_masterWREADY = 1'b1;
    step(); step();
    #1; total++;
    if ({int_masterAWVALID, MASTER_AWREADY, int_masterWVALID, MASTER_WREADY,
         outstanding_cnt, err_wlast, err_unexp_b} !== 9'b0) begin
      bad++;
      $display("FAIL reset_state: got vr=%b%b%b%b cnt=%0d errs=%b%b, want all 0",
               int_masterAWVALID, MASTER_AWREADY, int_masterWVALID, MASTER_WREADY,
               outstanding_cnt, err_wlast, err_unexp_b);
    end
    sysReset = 1'b0;
    #1; total++;
    if ({int_masterAWVALID, MASTER_AWREADY, int_masterWVALID, MASTER_WREADY} !== 4'b0) begin
      bad++;
      $display("FAIL first_cycle_after_release: got vr=%b%b%b%b, want 0000",
               int_masterAWVALID, MASTER_AWREADY, int_masterWVALID, MASTER_WREADY);
    end
    step();
    MASTER_AWVALID = 1'b0;
    #1; total++;
    if (MASTER_AWREADY !== 1'b1) begin
      bad++;
      $display("FAIL awready_after_release: got %b want 1", MASTER_AWREADY);
    end
    idle();
  endtask

  task automatic test_single_burst();
    MASTER_AWVALID = 1'b1; int_masterAWREADY = 1'b1; MASTER_AWLEN = 8'd3;
    #1; total++;
    if ({int_masterAWVALID, MASTER_AWREADY} !== 2'b11) begin
      bad++; $display("FAIL aw_pass: got %b%b want 11", int_masterAWVALID, MASTER_AWREADY);
    end
    step();
    MASTER_AWVALID = 1'b0;
    #1; total++;
    if (outstanding_cnt !== 3'd1) begin
      bad++; $display("FAIL cnt_after_aw: got %0d want 1", outstanding_cnt);
    end
    MASTER_WVALID = 1'b1; int_masterWREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      MASTER_WLAST = (i == 3);
      #1; total++;
      if ({int_masterWVALID, MASTER_WREADY, int_masterWLAST} !== {2'b11, i == 3}) begin
        bad++;
        $display("FAIL burst_beat%0d: got v/r/last=%b%b%b want 11%b", i,
                 int_masterWVALID, MASTER_WREADY, int_masterWLAST, i == 3);
      end
      step();
    end
    #1; total++;
    if ({int_masterWVALID, MASTER_WREADY} !== 2'b00) begin
      bad++; $display("FAIL burst_end_idle: got %b%b want 00", int_masterWVALID, MASTER_WREADY);
    end
    MASTER_WVALID = 1'b0;
    b_handshake(1);
    #1; total++;
    if ({outstanding_cnt, err_wlast, err_unexp_b} !== 5'b0) begin
      bad++;
      $display("FAIL cnt_after_b: got cnt=%0d errs=%b%b want 0,00",
               outstanding_cnt, err_wlast, err_unexp_b);
    end
    idle();
  endtask

  task automatic test_w_before_aw();
    MASTER_WVALID = 1'b1; int_masterWREADY = 1'b1; MASTER_WLAST = 1'b1; MASTER_AWLEN = 8'd0;
    for (int i = 0; i < 5; i++) begin
      #1; total++;
      if (MASTER_WREADY !== 1'b0) begin
        bad++; $display("FAIL w_held_off%0d: got %b want 0", i, MASTER_WREADY);
      end
      step();
    end
    MASTER_AWVALID = 1'b1; int_masterAWREADY = 1'b1;
    #1; total++;
    if ({MASTER_WREADY, MASTER_AWREADY} !== 2'b01) begin
      bad++; $display("FAIL w_in_aw_cycle: got wr/awr=%b%b want 01", MASTER_WREADY, MASTER_AWREADY);
    end
    step();
    MASTER_AWVALID = 1'b0;
    #1; total++;
    if ({MASTER_WREADY, int_masterWLAST} !== 2'b11) begin
      bad++; $display("FAIL w_after_aw: got wr/last=%b%b want 11", MASTER_WREADY, int_masterWLAST);
    end
    step();
    MASTER_WVALID = 1'b0;
    b_handshake(1);
    idle();
  endtask

  task automatic test_outstanding_cap();
    MASTER_AWLEN = 8'd0; MASTER_AWVALID = 1'b1; int_masterAWREADY = 1'b1;
    repeat (4) step();
    MASTER_WVALID = 1'b1; int_masterWREADY = 1'b1; MASTER_WLAST = 1'b1;
    #1; total++;
    if ({int_masterAWVALID, MASTER_AWREADY, outstanding_cnt} !== 5'b00100) begin
      bad++;
      $display("FAIL cap_blocks: got awv/awr=%b%b cnt=%0d want 00,4",
               int_masterAWVALID, MASTER_AWREADY, outstanding_cnt);
    end
    repeat (4) step();
    MASTER_WVALID = 1'b0;
    int_masterBVALID = 1'b1; MASTER_BREADY = 1'b1;
    #1; total++;
    if ({int_masterAWVALID, MASTER_AWREADY} !== 2'b00) begin
      bad++; $display("FAIL cap_blocks_fifo_empty: got %b%b want 00", int_masterAWVALID, MASTER_AWREADY);
    end
    step();
    int_masterBVALID = 1'b0; MASTER_BREADY = 1'b0;
    #1; total++;
    if ({int_masterAWVALID, MASTER_AWREADY, outstanding_cnt} !== 5'b11011) begin
      bad++;
      $display("FAIL cap_reopen: got awv/awr=%b%b cnt=%0d want 11,3",
               int_masterAWVALID, MASTER_AWREADY, outstanding_cnt);
    end
    step();
    MASTER_AWVALID = 1'b0;
    MASTER_WVALID = 1'b1;
    step();
    MASTER_WVALID = 1'b0;
    b_handshake(4);
    #1; total++;
    if (outstanding_cnt !== 3'd0) begin
      bad++; $display("FAIL cap_drain: got %0d want 0", outstanding_cnt);
    end
    idle();
  endtask

  task automatic test_aw_b_same_cycle();
    MASTER_AWLEN = 8'd0; MASTER_AWVALID = 1'b1; int_masterAWREADY = 1'b1;
    repeat (2) step();
    MASTER_AWVALID = 1'b0;
    MASTER_WVALID = 1'b1; int_masterWREADY = 1'b1; MASTER_WLAST = 1'b1;
    repeat (2) step();
    MASTER_WVALID = 1'b0;
    MASTER_AWVALID = 1'b1; int_masterBVALID = 1'b1; MASTER_BREADY = 1'b1;
    step();
    MASTER_AWVALID = 1'b0; int_masterBVALID = 1'b0; MASTER_BREADY = 1'b0;
    #1; total++;
    if (outstanding_cnt !== 3'd2) begin
      bad++; $display("FAIL aw_b_same: got %0d want 2", outstanding_cnt);
    end
    MASTER_WVALID = 1'b1;
    step();
    MASTER_WVALID = 1'b0;
    b_handshake(2);
    b_handshake(1);
    #1; total++;
    if ({err_unexp_b, outstanding_cnt} !== 4'b1000) begin
      bad++; $display("FAIL unexp_b: got err=%b cnt=%0d want 1,0", err_unexp_b, outstanding_cnt);
    end
    repeat (3) step();
    total++;
    if (err_unexp_b !== 1'b1) begin
      bad++; $display("FAIL unexp_b_sticky: got %b want 1", err_unexp_b);
    end
    idle();
  endtask

  task automatic test_wlast_err();
    sysReset = 1'b1; step(); sysReset = 1'b0; step();
    MASTER_AWLEN = 8'd3; MASTER_AWVALID = 1'b1; int_masterAWREADY = 1'b1;
    step();
    MASTER_AWVALID = 1'b0;
    MASTER_WVALID = 1'b1; int_masterWREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      MASTER_WLAST = (i == 1);
      #1; total++;
      if ({int_masterWVALID, int_masterWLAST} !== {1'b1, i == 3}) begin
        bad++;
        $display("FAIL wlast_regen%0d: got v/last=%b%b want 1%b", i,
                 int_masterWVALID, int_masterWLAST, i == 3);
      end
      step();
      if (i == 1) begin
        total++;
        if (err_wlast !== 1'b1) begin
          bad++; $display("FAIL err_wlast_set: got %b want 1", err_wlast);
        end
      end
    end
    #1; total++;
    if ({int_masterWVALID, err_wlast} !== 2'b01) begin
      bad++; $display("FAIL wlast_burst_len: got wv/err=%b%b want 01", int_masterWVALID, err_wlast);
    end
    MASTER_WVALID = 1'b0;
    b_handshake(1);
    idle();
  endtask

  task automatic test_long_burst();
    int lasts;
    lasts = 0;
    MASTER_AWLEN = 8'd255; MASTER_AWVALID = 1'b1; int_masterAWREADY = 1'b1;
    step();
    MASTER_AWVALID = 1'b0;
    MASTER_WVALID = 1'b1; int_masterWREADY = 1'b1;
    for (int i = 0; i < 256; i++) begin
      MASTER_WLAST = (i == 255);
      #1;
      if (int_masterWLAST === 1'b1) lasts++;
      if (i == 255) begin
        total++;
        if (int_masterWLAST !== 1'b1 || lasts != 1) begin
          bad++; $display("FAIL len255_last: got last=%b count=%0d want 1,1", int_masterWLAST, lasts);
        end
      end
      step();
    end
    #1; total++;
    if (int_masterWVALID !== 1'b0) begin
      bad++; $display("FAIL len255_end: got wv=%b want 0", int_masterWVALID);
    end
    MASTER_WVALID = 1'b0;
    b_handshake(1);
    idle();
  endtask

  task automatic test_reset_midburst();
    int_masterAWREADY = 1'b1; MASTER_AWVALID = 1'b1;
    MASTER_AWLEN = 8'd7; step();
    MASTER_AWLEN = 8'd2; step(); step();
    MASTER_AWVALID = 1'b0;
    MASTER_WVALID = 1'b1; int_masterWREADY = 1'b1; MASTER_WLAST = 1'b0;
    step();
    MASTER_AWVALID = 1'b1; int_masterBVALID = 1'b1;
    sysReset = 1'b1;
    step();
    #1; total++;
    if ({int_masterAWVALID, MASTER_AWREADY, int_masterWVALID, MASTER_WREADY, int_masterWLAST,
         outstanding_cnt, err_wlast, err_unexp_b} !== 10'b0) begin
      bad++;
      $display("FAIL reset_midburst: got vr=%b%b%b%b last=%b cnt=%0d errs=%b%b want all 0",
               int_masterAWVALID, MASTER_AWREADY, int_masterWVALID, MASTER_WREADY,
               int_masterWLAST, outstanding_cnt, err_wlast, err_unexp_b);
    end
    idle();
    sysReset = 1'b0;
    step(); step();
  endtask

  task automatic test_random();
    logic [9:0] got;
    logic [9:0] exp;
    for (int c = 0; c < 4000; c++) begin
      sysReset          = ($urandom_range(0, 299) == 0);
      MASTER_AWVALID    = $urandom_range(0, 1);
      int_masterAWREADY = ($urandom_range(0, 3) != 0);
      MASTER_AWLEN      = ($urandom_range(0, 49) == 0) ? 8'd255 : 8'($urandom_range(0, 5));
      MASTER_WVALID     = ($urandom_range(0, 3) != 0);
      int_masterWREADY  = ($urandom_range(0, 3) != 0);
      MASTER_WLAST      = e_wlast() ^ ($urandom_range(0, 63) == 0);
      int_masterBVALID  = (m_cnt > 0 || $urandom_range(0, 99) == 0) && $urandom_range(0, 1);
      int_masterBID     = 1'($urandom_range(0, 1));
      MASTER_BREADY     = ($urandom_range(0, 3) != 0);
      #1;
      exp = {MASTER_AWVALID && m_space(), int_masterAWREADY && m_space(),
             MASTER_WVALID && m_wact(), int_masterWREADY && m_wact(), e_wlast(),
             3'(m_cnt), m_errw, m_errb};
      got = {int_masterAWVALID, MASTER_AWREADY, int_masterWVALID, MASTER_WREADY,
             int_masterWLAST, outstanding_cnt, err_wlast, err_unexp_b};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random_cycle%0d: got {awv,awr,wv,wr,last,cnt,errw,errb}=%b want %b", c, got, exp);
      end
      step();
    end
    sysReset = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_burst();
    test_w_before_aw();
    test_outstanding_cap();
    test_aw_b_same_cycle();
    test_wlast_err();
    test_long_burst();
    test_reset_midburst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
